// File: rtl/btb_pkg.sv
// Shared sizing and way-select constants for the branch target buffer
// and the direction predictor that indexes alongside it.
package btb_pkg;

  localparam int unsigned IDX_W_DEF = 6;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned TGT_W     = 30;

  typedef enum logic {
    WAY0 = 1'b0,
    WAY1 = 1'b1
  } way_e;

  // Tag covers every PC bit above the set index and the byte offset.
  function automatic int unsigned tag_w(input int unsigned idx_w);
    return 30 - idx_w;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: valid/tag/target arrays, a single write port, an async
// lookup port and a tag probe at the write index for hit/allocate decisions.
module btb_way
  import btb_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned TAG_W = tag_w(IDX_W_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [TGT_W-1:0] wr_tgt,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit_c,
  output logic [TGT_W-1:0] rd_tgt_c,
  output logic             wr_valid_c,
  output logic             wr_hit_c
);

  localparam int unsigned SETS = 1 << IDX_W;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  valid_d;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [TGT_W-1:0] tgt_q [SETS];

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= wr_tgt;
    end
  end

  assign rd_hit_c   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_tgt_c   = tgt_q[rd_idx];
  assign wr_valid_c = valid_q[wr_idx];
  assign wr_hit_c   = wr_valid_c && (tag_q[wr_idx] == wr_tag);

endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer: F-stage lookup registered into D,
// M-stage training on taken branches with one LRU bit per set.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallD,
  input  logic            flushD,
  input  logic [PC_W-1:0] pcF,
  input  logic            branchM,
  input  logic            actual_takeM,
  input  logic [PC_W-1:0] pcM,
  input  logic [PC_W-1:0] targetM,
  output logic            btb_hitD,
  output logic [PC_W-1:0] btb_targetD
);

  localparam int unsigned TAG_W = tag_w(IDX_W);
  localparam int unsigned SETS  = 1 << IDX_W;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [TGT_W-1:0] wr_tgt;
  logic             unused_pc_lsbs;

  assign rd_idx         = pcF[IDX_W+1:2];
  assign rd_tag         = pcF[PC_W-1:IDX_W+2];
  assign wr_idx         = pcM[IDX_W+1:2];
  assign wr_tag         = pcM[PC_W-1:IDX_W+2];
  assign wr_tgt         = targetM[PC_W-1:2];
  assign unused_pc_lsbs = ^{pcF[1:0], pcM[1:0], targetM[1:0]};

  logic [1:0]       we_c;
  logic [1:0]       rd_hit_c;
  logic [1:0]       wr_hit_c;
  logic [1:0]       wr_valid_c;
  logic [TGT_W-1:0] rd_tgt0_c;
  logic [TGT_W-1:0] rd_tgt1_c;

  btb_way #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst(rst), .we(we_c[0]),
    .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_tgt(wr_tgt),
    .rd_idx(rd_idx), .rd_tag(rd_tag),
    .rd_hit_c(rd_hit_c[0]), .rd_tgt_c(rd_tgt0_c),
    .wr_valid_c(wr_valid_c[0]), .wr_hit_c(wr_hit_c[0])
  );

  btb_way #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst(rst), .we(we_c[1]),
    .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_tgt(wr_tgt),
    .rd_idx(rd_idx), .rd_tag(rd_tag),
    .rd_hit_c(rd_hit_c[1]), .rd_tgt_c(rd_tgt1_c),
    .wr_valid_c(wr_valid_c[1]), .wr_hit_c(wr_hit_c[1])
  );

  logic [SETS-1:0] lru_q;
  logic [SETS-1:0] lru_d;
  way_e            victim;

  // Way choice: tag hit, then first invalid way, then the LRU way.
  always_comb begin
    lru_d  = lru_q;
    we_c   = '0;
    victim = WAY0;
    if (branchM && actual_takeM) begin
      if (wr_hit_c[0])         victim = WAY0;
      else if (wr_hit_c[1])    victim = WAY1;
      else if (!wr_valid_c[0]) victim = WAY0;
      else if (!wr_valid_c[1]) victim = WAY1;
      else                     victim = way_e'(lru_q[wr_idx]);
      we_c[1'(victim)] = 1'b1;
      lru_d[wr_idx]    = ~1'(victim);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lru_q <= '0;
    else      lru_q <= lru_d;
  end

  logic             hit_q;
  logic             hit_d;
  logic [TGT_W-1:0] tgt_q;
  logic [TGT_W-1:0] tgt_d;

  // D register: flush beats stall; the update rule keeps hits one-hot.
  always_comb begin
    hit_d = hit_q;
    tgt_d = tgt_q;
    if (flushD) begin
      hit_d = 1'b0;
      tgt_d = '0;
    end else if (!stallD) begin
      hit_d = |rd_hit_c;
      if (rd_hit_c[1])      tgt_d = rd_tgt1_c;
      else if (rd_hit_c[0]) tgt_d = rd_tgt0_c;
      else                  tgt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q <= 1'b0;
      tgt_q <= '0;
    end else begin
      hit_q <= hit_d;
      tgt_q <= tgt_d;
    end
  end

  assign btb_hitD    = hit_q;
  assign btb_targetD = {tgt_q, 2'b00};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios plus random traffic checked
// against a per-set recency-list model of a 2-entry LRU cache.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD;
  logic        flushD;
  logic [31:0] pcF;
  logic        branchM;
  logic        actual_takeM;
  logic [31:0] pcM;
  logic [31:0] targetM;
  logic        btb_hitD;
  logic [31:0] btb_targetD;

  int n_tests = 0;
  int n_fail  = 0;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcF(pcF),
    .branchM(branchM), .actual_takeM(actual_takeM), .pcM(pcM), .targetM(targetM),
    .btb_hitD(btb_hitD), .btb_targetD(btb_targetD)
  );

  always #5 clk = ~clk;

  // Model: per set, entries ordered most-recently-trained first, at most two.
  logic [23:0] m_tag [64][2];
  logic [29:0] m_tgt [64][2];
  int          m_n   [64];
  logic        exp_hit;
  logic [31:0] exp_tgt;

  task automatic mdl_reset();
    for (int s = 0; s < 64; s++) m_n[s] = 0;
    exp_hit = 1'b0;
    exp_tgt = 32'h0;
  endtask

  function automatic int mdl_find(input int s, input logic [23:0] t);
    for (int i = 0; i < m_n[s]; i++)
      if (m_tag[s][i] == t) return i;
    return -1;
  endfunction

  task automatic mdl_update(input logic [31:0] pc, input logic [31:0] tg);
    int s;
    int k;
    s = int'(pc[7:2]);
    k = mdl_find(s, pc[31:8]);
    if (k != 0) begin
      m_tag[s][1] = m_tag[s][0];
      m_tgt[s][1] = m_tgt[s][0];
      if (k < 0 && m_n[s] < 2) m_n[s] = m_n[s] + 1;
    end
    m_tag[s][0] = pc[31:8];
    m_tgt[s][0] = tg[31:2];
  endtask

  // One clock: model sees pre-update contents for lookup, then applies training.
  task automatic tick();
    int s;
    int k;
    s = int'(pcF[7:2]);
    k = mdl_find(s, pcF[31:8]);
    if (flushD) begin
      exp_hit = 1'b0;
      exp_tgt = 32'h0;
    end else if (!stallD) begin
      exp_hit = (k >= 0);
      exp_tgt = (k >= 0) ? {m_tgt[s][k], 2'b00} : 32'h0;
    end
    if (branchM && actual_takeM) mdl_update(pcM, targetM);
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tg);
    branchM = 1'b1; actual_takeM = 1'b1; pcM = pc; targetM = tg;
    tick();
    branchM = 1'b0; actual_takeM = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; pcF = 32'h0000_0040;
    repeat (2) @(negedge clk);
    n_tests++;
    if (btb_hitD !== 1'b0 || btb_targetD !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held: hit=%0b tgt=%08h want hit=0 tgt=00000000", btb_hitD, btb_targetD);
    end
    mdl_reset();
    rst = 1'b1;
    tick();
    n_tests++;
    if (btb_hitD !== 1'b0 || btb_targetD !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_lookup: hit=%0b tgt=%08h want hit=0 tgt=00000000", btb_hitD, btb_targetD);
    end
  endtask

  task automatic test_train_hit();
    pcF = 32'h0000_0040;
    train(32'h0000_0100, 32'h0000_0200);
    pcF = 32'h0000_0100;
    tick();
    n_tests++;
    if (btb_hitD !== 1'b1 || btb_targetD !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL train_hit: hit=%0b tgt=%08h want hit=1 tgt=00000200", btb_hitD, btb_targetD);
    end
  endtask

  task automatic test_not_taken();
    branchM = 1'b1; actual_takeM = 1'b0; pcM = 32'h0000_0100; targetM = 32'h0000_0300;
    pcF = 32'h0000_0100;
    tick();
    branchM = 1'b0;
    tick();
    n_tests++;
    if (btb_hitD !== 1'b1 || btb_targetD !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL not_taken: hit=%0b tgt=%08h want hit=1 tgt=00000200", btb_hitD, btb_targetD);
    end
  endtask

  task automatic test_lru_conflict();
    logic [31:0] pcs  [3];
    logic [31:0] want [3];
    logic        wh   [3];
    pcs[0] = 32'h0000_1000; want[0] = 32'h0;          wh[0] = 1'b0;
    pcs[1] = 32'h0000_2000; want[1] = 32'h0000_B000; wh[1] = 1'b1;
    pcs[2] = 32'h0000_3000; want[2] = 32'h0000_C000; wh[2] = 1'b1;
    pcF = 32'h0000_0040;
    train(32'h0000_1000, 32'h0000_A000);
    train(32'h0000_2000, 32'h0000_B000);
    train(32'h0000_3000, 32'h0000_C000);
    for (int i = 0; i < 3; i++) begin
      pcF = pcs[i];
      tick();
      n_tests++;
      if (btb_hitD !== wh[i] || btb_targetD !== want[i]) begin
        n_fail++;
        $display("FAIL lru_conflict[%0d]: hit=%0b tgt=%08h want hit=%0b tgt=%08h",
                 i, btb_hitD, btb_targetD, wh[i], want[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    pcF = 32'h0000_0500;
    branchM = 1'b1; actual_takeM = 1'b1; pcM = 32'h0000_0500; targetM = 32'h0000_0600;
    tick();
    branchM = 1'b0; actual_takeM = 1'b0;
    n_tests++;
    if (btb_hitD !== 1'b0 || btb_targetD !== 32'h0) begin
      n_fail++;
      $display("FAIL same_cycle_rbw: hit=%0b tgt=%08h want hit=0 tgt=00000000", btb_hitD, btb_targetD);
    end
    tick();
    n_tests++;
    if (btb_hitD !== 1'b1 || btb_targetD !== 32'h0000_0600) begin
      n_fail++;
      $display("FAIL same_cycle_next: hit=%0b tgt=%08h want hit=1 tgt=00000600", btb_hitD, btb_targetD);
    end
  endtask

  task automatic test_pipeline_ctrl();
    pcF = 32'h0000_3000;
    tick();
    stallD = 1'b1;
    pcF = 32'h0000_1000;
    tick();
    pcF = 32'h0000_0500;
    tick();
    n_tests++;
    if (btb_hitD !== 1'b1 || btb_targetD !== 32'h0000_C000) begin
      n_fail++;
      $display("FAIL stall_hold: hit=%0b tgt=%08h want hit=1 tgt=0000c000", btb_hitD, btb_targetD);
    end
    flushD = 1'b1;
    tick();
    n_tests++;
    if (btb_hitD !== 1'b0 || btb_targetD !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_over_stall: hit=%0b tgt=%08h want hit=0 tgt=00000000", btb_hitD, btb_targetD);
    end
    flushD = 1'b0; stallD = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] p;
    for (int i = 0; i < 400; i++) begin
      p = {22'(0), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 2)), 2'($urandom)};
      pcF          = {p[31:16], 8'($urandom_range(0, 3)), p[7:0]};
      p            = {22'(0), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 2)), 2'($urandom)};
      pcM          = {p[31:16], 8'($urandom_range(0, 3)), p[7:0]};
      targetM      = $urandom;
      branchM      = ($urandom_range(0, 99) < 60);
      actual_takeM = ($urandom_range(0, 99) < 70);
      stallD       = ($urandom_range(0, 99) < 10);
      flushD       = ($urandom_range(0, 99) < 5);
      tick();
      n_tests++;
      if (btb_hitD !== exp_hit || btb_targetD !== exp_tgt) begin
        n_fail++;
        $display("FAIL random[%0d] pcF=%08h: hit=%0b tgt=%08h want hit=%0b tgt=%08h",
                 i, pcF, btb_hitD, btb_targetD, exp_hit, exp_tgt);
      end
    end
    branchM = 1'b0; actual_takeM = 1'b0; stallD = 1'b0; flushD = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] pcs [2];
    pcs[0] = 32'h0000_2000;
    pcs[1] = 32'h0000_0100;
    train(32'h0000_2000, 32'h0000_B000);
    pcF = 32'h0000_2000;
    tick();
    n_tests++;
    if (btb_hitD !== exp_hit || btb_targetD !== exp_tgt) begin
      n_fail++;
      $display("FAIL pre_reset: hit=%0b tgt=%08h want hit=%0b tgt=%08h",
               btb_hitD, btb_targetD, exp_hit, exp_tgt);
    end
    branchM = 1'b1; actual_takeM = 1'b1; pcM = 32'h0000_0100; targetM = 32'h0000_0700;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (btb_hitD !== 1'b0 || btb_targetD !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: hit=%0b tgt=%08h want hit=0 tgt=00000000", btb_hitD, btb_targetD);
    end
    mdl_reset();
    @(negedge clk);
    rst = 1'b1; branchM = 1'b0; actual_takeM = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pcF = pcs[i];
      tick();
      n_tests++;
      if (btb_hitD !== 1'b0 || btb_targetD !== 32'h0) begin
        n_fail++;
        $display("FAIL post_reset_miss[%0d]: hit=%0b tgt=%08h want hit=0 tgt=00000000",
                 i, btb_hitD, btb_targetD);
      end
    end
  endtask

  initial begin
    rst = 1'b0; stallD = 1'b0; flushD = 1'b0; pcF = 32'h0;
    branchM = 1'b0; actual_takeM = 1'b0; pcM = 32'h0; targetM = 32'h0;
    mdl_reset();
    test_reset();
    test_train_hit();
    test_not_taken();
    test_lru_conflict();
    test_same_cycle();
    test_pipeline_ctrl();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
